pc_fetch_unit: RTL and testbench

- Instruction-fetch program counter block: a 64-bit PC register plus two combinational adders.
  - Sequential adder: pc_out + inc.
  - Branch-target adder: pc_out + (sign-extended offset << 2).
- Sits at the front of the fetch stage; the next-PC mux lives outside this block and drives pc_in.
- Typical closed loop: adder_out is fed back to pc_in for straight-line fetch.

---
 rtl/pc_fetch_unit_if.sv | 34 +++
 rtl/pc_fetch_unit.sv | 47 ++++
 tb/tb_pc_fetch_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-PC handshake bundle: next-PC/control in, PC and adder results out.
// Optional PC_ALIGN_CHECK_EN adds the registered misaligned flag.
interface pc_fetch_unit_if #(
    parameter int WIDTH = 64,
    parameter int INC_W = 4,
    parameter int OFF_W = 26
);
    logic             en;
    logic [WIDTH-1:0] pc_in;
    logic [INC_W-1:0] inc;
    logic [OFF_W-1:0] br_off;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] adder_out;
    logic [WIDTH-1:0] br_target;
`ifdef PC_ALIGN_CHECK_EN
    logic             misaligned;
`endif

    modport master (
        output en, pc_in, inc, br_off,
        input  pc_out, adder_out, br_target
`ifdef PC_ALIGN_CHECK_EN
        , input misaligned
`endif
    );

    modport slave (
        input  en, pc_in, inc, br_off,
        output pc_out, adder_out, br_target
`ifdef PC_ALIGN_CHECK_EN
        , output misaligned
`endif
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with sequential and branch-target adders.
// Define PC_ALIGN_CHECK_EN to add the registered misaligned flag.
module pc_fetch_unit #(
    parameter int               WIDTH        = 64,
    parameter int               INC_W        = 4,
    parameter int               OFF_W        = 26,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic clk,
    input logic rst,
    pc_fetch_unit_if.slave bus
);
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_inc_ext;
    logic [WIDTH-1:0] w_br_disp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_VECTOR;
        end else if (bus.en) begin
            r_pc <= bus.pc_in;
        end
    end

    // Word offset becomes a byte displacement: sign-extend, then scale by 4.
    assign w_inc_ext = {{(WIDTH-INC_W){1'b0}}, bus.inc};
    assign w_br_disp = {{(WIDTH-OFF_W-2){bus.br_off[OFF_W-1]}},
                        bus.br_off, 2'b00};

    assign bus.pc_out    = r_pc;
    assign bus.adder_out = r_pc + w_inc_ext;
    assign bus.br_target = r_pc + w_br_disp;

`ifdef PC_ALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misaligned <= 1'b0;
        end else if (bus.en) begin
            r_misaligned <= (bus.pc_in[1:0] != 2'b00);
        end
    end

    assign bus.misaligned = r_misaligned;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed table, corner sequences
// and randomized traffic against an arithmetic reference model.
module tb_pc_fetch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [63:0] pc_in;
        logic [3:0]  inc;
        logic [25:0] br_off;
        logic [63:0] exp_pc;
        logic [63:0] exp_add;
        logic [63:0] exp_br;
    } vec_t;

    vec_t vt[10];

    logic [63:0] m_pc;
    logic        m_mis;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_br(input logic [63:0] pc,
                                           input logic [25:0] off);
        longint d;
        d = longint'($signed(off)) * 4;
        return pc + 64'(d);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.pc_in = '0;
        bus.inc = 4'd4;
        bus.br_off = '0;
        #1 rst = 1'b0;
        #2;
        chk("reset_pc_async", bus.pc_out, 64'd0);
        chk("reset_adder", bus.adder_out, 64'd4);
        chk("reset_br", bus.br_target, 64'd0);
        bus.en = 1'b1;
        bus.pc_in = 64'd123;
        step();
        step();
        chk("reset_holds_pc", bus.pc_out, 64'd0);
`ifdef PC_ALIGN_CHECK_EN
        chk("reset_mis", {63'd0, bus.misaligned}, 64'd0);
`endif

        rst = 1'b1;
        bus.pc_in = 64'd8;
        step();
        chk("load_pc", bus.pc_out, 64'd8);
        chk("load_adder", bus.adder_out, 64'd12);

        for (int i = 0; i < 4; i++) begin
            bus.pc_in = bus.adder_out;
            step();
            chk("feedback_pc", bus.pc_out, 64'd12 + 64'(4 * i));
            chk("feedback_adder", bus.adder_out, 64'd16 + 64'(4 * i));
        end

        vt[0] = '{1'b1, 64'd16, 4'd4, 26'd0, 64'd16, 64'd20, 64'd16};
        vt[1] = '{1'b0, 64'd20, 4'd4, 26'd0, 64'd16, 64'd20, 64'd16};
        vt[2] = '{1'b0, 64'd20, 4'd4, 26'd0, 64'd16, 64'd20, 64'd16};
        vt[3] = '{1'b0, 64'd20, 4'd4, 26'd0, 64'd16, 64'd20, 64'd16};
        vt[4] = '{1'b1, 64'd20, 4'd4, 26'd0, 64'd20, 64'd24, 64'd20};
        vt[5] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 4'd4, 26'd0,
                  64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC};
        vt[6] = '{1'b1, 64'd100, 4'd0, 26'h3FF_FFFF,
                  64'd100, 64'd100, 64'd96};
        vt[7] = '{1'b0, 64'd0, 4'd4, 26'd3, 64'd100, 64'd104, 64'd112};
        vt[8] = '{1'b1, 64'd0, 4'd4, 26'h3FF_FFFF,
                  64'd0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC};
        vt[9] = '{1'b1, 64'd24, 4'd15, 26'h200_0000,
                  64'd24, 64'd39, 64'd24 - 64'h800_0000};

        for (int i = 0; i < 10; i++) begin
            bus.en = vt[i].en;
            bus.pc_in = vt[i].pc_in;
            bus.inc = vt[i].inc;
            bus.br_off = vt[i].br_off;
            step();
            chk($sformatf("vec%0d_pc", i), bus.pc_out, vt[i].exp_pc);
            chk($sformatf("vec%0d_adder", i), bus.adder_out, vt[i].exp_add);
            chk($sformatf("vec%0d_br", i), bus.br_target, vt[i].exp_br);
        end

        bus.inc = 4'd4;
        bus.br_off = '0;
        #2 rst = 1'b0;
        #1;
        chk("midrun_reset_pc", bus.pc_out, 64'd0);
        chk("midrun_reset_adder", bus.adder_out, 64'd4);

`ifdef PC_ALIGN_CHECK_EN
        step();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.pc_in = 64'd6;
        step();
        chk("mis_set", {63'd0, bus.misaligned}, 64'd1);
        bus.en = 1'b0;
        bus.pc_in = 64'd8;
        step();
        chk("mis_hold", {63'd0, bus.misaligned}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("mis_reset_clear", {63'd0, bus.misaligned}, 64'd0);
`endif

        step();
        rst = 1'b1;
        m_pc = 64'd0;
        m_mis = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.en = ($urandom_range(0, 3) != 0);
            bus.pc_in = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1) bus.pc_in[1:0] = 2'b00;
            bus.inc = 4'($urandom());
            bus.br_off = 26'($urandom());
            step();
            if (bus.en) begin
                m_pc = bus.pc_in;
                m_mis = (bus.pc_in % 4) != 0;
            end
            chk("rand_pc", bus.pc_out, m_pc);
            chk("rand_adder", bus.adder_out, m_pc + 64'(bus.inc));
            chk("rand_br", bus.br_target, ref_br(m_pc, bus.br_off));
`ifdef PC_ALIGN_CHECK_EN
            chk("rand_mis", {63'd0, bus.misaligned}, {63'd0, m_mis});
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
